// File: rtl/result_collector.sv
// result_collector: ping-pong result buffer that hands filled or flushed banks to the copier.
// Optional statistics counters are built when RESULT_COLLECTOR_STATS_EN is defined.
module result_collector #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
  output logic        copy_kick,
  input  logic        copy_busy,
  output logic [31:0] copy_offset,
  output logic [31:0] copy_words,
  input  logic [31:0] rd_addr,
  output logic [63:0] rd_q,
  output logic        done,
  output logic [31:0] stat_words,
  output logic [31:0] stat_stall
);
  localparam int BANK_WORDS = 1 << (ADDR_W - 1);
  localparam int DEPTH      = 1 << ADDR_W;

  typedef enum logic [1:0] {
    K_IDLE = 2'd0,
    K_ACK  = 2'd1,
    K_WAIT = 2'd2
  } k_state_e;

  logic [63:0]             mem [DEPTH];
  logic                    wr_bank_q, wr_bank_d;
  logic [ADDR_W-2:0]       wr_count_q, wr_count_d;
  logic [1:0]              sealed_q, sealed_d;
  logic [1:0][ADDR_W-1:0]  len_q, len_d;
  logic [1:0]              last_q, last_d;
  k_state_e                k_state_q, k_state_d;
  logic                    k_bank_q, k_bank_d;
  logic                    kick_q, kick_d;
  logic [31:0]             offset_q, offset_d;
  logic [31:0]             words_q, words_d;
  logic                    done_q, done_d;
  logic [63:0]             rd_data_q;
  logic                    accept_s, bank_full_s, clear_s, ready_s;
  logic                    rd_addr_unused_s;

  assign ready_s          = ~sealed_q[wr_bank_q];
  assign accept_s         = s_valid & ready_s;
  assign bank_full_s      = (wr_count_q == {(ADDR_W-1){1'b1}});
  assign rd_addr_unused_s = ^rd_addr[31:ADDR_W];

  assign s_ready     = ready_s;
  assign copy_kick   = kick_q;
  assign copy_offset = offset_q;
  assign copy_words  = words_q;
  assign rd_q        = rd_data_q;
  assign done        = done_q;

  // Writer: bank fill pointer and per-bank seal bookkeeping; kicker clears a bank independently.
  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_count_d = wr_count_q;
    sealed_d   = sealed_q;
    len_d      = len_q;
    last_d     = last_q;
    if (clear_s) begin
      sealed_d[k_bank_q] = 1'b0;
    end else begin
      sealed_d[k_bank_q] = sealed_q[k_bank_q];
    end
    if (accept_s && (bank_full_s || s_last)) begin
      sealed_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]    = {1'b0, wr_count_q} + ADDR_W'(1'b1);
      last_d[wr_bank_q]   = s_last;
      wr_bank_d           = ~wr_bank_q;
      wr_count_d          = {(ADDR_W-1){1'b0}};
    end else if (accept_s) begin
      wr_count_d = wr_count_q + (ADDR_W-1)'(1'b1);
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  // Kicker: hands sealed banks to the copier strictly in fill order.
  always_comb begin
    k_state_d = k_state_q;
    k_bank_d  = k_bank_q;
    kick_d    = kick_q;
    offset_d  = offset_q;
    words_d   = words_q;
    done_d    = 1'b0;
    clear_s   = 1'b0;
    case (k_state_q)
      K_IDLE: begin
        if (sealed_q[k_bank_q] && !copy_busy) begin
          kick_d    = 1'b1;
          offset_d  = k_bank_q ? 32'(BANK_WORDS) : 32'd0;
          words_d   = 32'(len_q[k_bank_q]);
          k_state_d = K_ACK;
        end else begin
          kick_d    = 1'b0;
        end
      end
      K_ACK: begin
        kick_d = 1'b0;
        if (copy_busy) begin
          k_state_d = K_WAIT;
        end else begin
          k_state_d = K_ACK;
        end
      end
      K_WAIT: begin
        if (!copy_busy) begin
          clear_s   = 1'b1;
          k_bank_d  = ~k_bank_q;
          done_d    = last_q[k_bank_q];
          k_state_d = K_IDLE;
        end else begin
          k_state_d = K_WAIT;
        end
      end
      default: begin
        kick_d    = 1'b0;
        k_state_d = K_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q  <= 1'b0;
      wr_count_q <= {(ADDR_W-1){1'b0}};
      sealed_q   <= 2'b00;
      len_q      <= {(2*ADDR_W){1'b0}};
      last_q     <= 2'b00;
      k_state_q  <= K_IDLE;
      k_bank_q   <= 1'b0;
      kick_q     <= 1'b0;
      offset_q   <= 32'd0;
      words_q    <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_count_q <= wr_count_d;
      sealed_q   <= sealed_d;
      len_q      <= len_d;
      last_q     <= last_d;
      k_state_q  <= k_state_d;
      k_bank_q   <= k_bank_d;
      kick_q     <= kick_d;
      offset_q   <= offset_d;
      words_q    <= words_d;
      done_q     <= done_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem[{wr_bank_q, wr_count_q}] <= s_data;
    end
  end

  // Registered read port, unconditional and read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 64'd0;
    end else begin
      rd_data_q <= mem[rd_addr[ADDR_W-1:0]];
    end
  end

`ifdef RESULT_COLLECTOR_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Statistics next-state: accepted beats and back-pressured cycles, both wrapping.
  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (accept_s) begin
      stat_words_d = stat_words_q + 32'd1;
    end else begin
      stat_words_d = stat_words_q;
    end
    if (s_valid && !ready_s) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end else begin
      stat_stall_d = stat_stall_q;
    end
  end

  // Statistics registers, cleared by reset only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_words_q <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_words = 32'd0;
  assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector (ADDR_W=4, 8-word banks, copier busy 20 cycles per kick).
`timescale 1ns/1ps
module tb_result_collector;
  localparam int AW = 4;
  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [63:0] s_data = 64'd0;
  logic [31:0] rd_addr = 32'd0;
  logic        copy_busy;
  logic        s_ready, copy_kick, done;
  logic [31:0] copy_offset, copy_words, stat_words, stat_stall;
  logic [63:0] rd_q;

  result_collector #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .copy_kick(copy_kick), .copy_busy(copy_busy), .copy_offset(copy_offset),
    .copy_words(copy_words), .rd_addr(rd_addr), .rd_q(rd_q), .done(done),
    .stat_words(stat_words), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Copier model and observation state
  bit          cp_hold = 1'b0;
  bit          cp_busy = 1'b0;
  int          cp_cnt = 0;
  int          cp_left = 0;
  logic [31:0] cp_base = 32'd0;
  logic [31:0] cp_ptr = 32'd0;
  bit          rd_pend = 1'b0;
  logic [31:0] kick_off_q[$];
  logic [31:0] kick_words_q[$];
  logic [63:0] got_q[$];
  int          done_n = 0;
  int          done_kicks = 0;

  // Reference model: stream chopped into banks of BW words, split early at s_last
  logic [31:0] exp_off_q[$];
  logic [31:0] exp_words_q[$];
  logic [63:0] exp_data_q[$];
  int          m_bank = 0;
  int          m_cnt = 0;
  int          exp_done = 0;
  int          stall_obs = 0;
  int          beats_acc = 0;
  bit          first_ready = 1'b1;

  assign copy_busy = cp_busy;

  always @(posedge clk) begin
    #1;
    if (rd_pend) got_q.push_back(rd_q);
    rd_pend = 1'b0;
    if (done === 1'b1) begin
      done_n++;
      done_kicks = kick_off_q.size();
    end
    if (copy_kick === 1'b1) begin
      kick_off_q.push_back(copy_offset);
      kick_words_q.push_back(copy_words);
      cp_cnt  = 20;
      cp_base = copy_offset;
      cp_ptr  = 32'd0;
      cp_left = (copy_words > 32'(BW)) ? BW : int'(copy_words);
    end else if (cp_cnt > 0) begin
      cp_cnt--;
    end
    if (cp_left > 0) begin
      rd_addr = cp_base + cp_ptr;
      cp_ptr  = cp_ptr + 32'd1;
      cp_left--;
      rd_pend = 1'b1;
    end
    cp_busy = cp_hold || (cp_cnt > 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  function automatic void model_push(input logic [63:0] d, input bit l);
    exp_data_q.push_back(d);
    m_cnt++;
    if (m_cnt == BW || l) begin
      exp_off_q.push_back(32'(m_bank * BW));
      exp_words_q.push_back(32'(m_cnt));
      m_bank = 1 - m_bank;
      m_cnt  = 0;
      if (l) exp_done++;
    end
  endfunction

  task automatic do_reset(input bit keep_busy);
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    kick_off_q.delete(); kick_words_q.delete(); got_q.delete();
    exp_off_q.delete(); exp_words_q.delete(); exp_data_q.delete();
    m_bank = 0; m_cnt = 0; exp_done = 0; done_n = 0; done_kicks = 0;
    stall_obs = 0; beats_acc = 0; cp_left = 0; rd_pend = 1'b0;
    if (!keep_busy) cp_cnt = 0;
    cp_busy = cp_hold || (cp_cnt > 0);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input bit l);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    #1;
    first_ready = s_ready;
    while (s_ready !== 1'b1 && n < 500) begin
      stall_obs++;
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      vectors++; miscompares++;
      $display("FAIL send_beat_timeout ready=%b required 1", s_ready);
    end else begin
      @(posedge clk);
      beats_acc++;
      model_push(d, l);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    while ((done_n < target || cp_busy || cp_left > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL wait_done_timeout done=%0d required %0d", done_n, target);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b required 1", s_ready); end
    vectors++; if (copy_kick !== 1'b0) begin miscompares++; $display("FAIL rst_kick got %b required 0", copy_kick); end
    vectors++; if (copy_offset !== 32'd0 || copy_words !== 32'd0) begin miscompares++; $display("FAIL rst_offwords got %0d,%0d required 0,0", copy_offset, copy_words); end
    vectors++; if (rd_q !== 64'd0) begin miscompares++; $display("FAIL rst_rdq got %h required 0", rd_q); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b required 0", done); end
    vectors++; if (stat_words !== 32'd0 || stat_stall !== 32'd0) begin miscompares++; $display("FAIL rst_stats got %0d,%0d required 0,0", stat_words, stat_stall); end
    release_reset();
  endtask

  task automatic test_single();
    do_reset(1'b0);
    release_reset();
    send_beat(64'h11, 1'b0);
    send_beat(64'h12, 1'b0);
    send_beat(64'h13, 1'b1);
    wait_done(1);
    vectors++;
    if (kick_off_q.size() != 1) begin
      miscompares++; $display("FAIL single_kicks got %0d required 1", kick_off_q.size());
    end else if (kick_off_q[0] !== 32'd0 || kick_words_q[0] !== 32'd3) begin
      miscompares++; $display("FAIL single_kick got (%0d,%0d) required (0,3)", kick_off_q[0], kick_words_q[0]);
    end
    vectors++;
    if (got_q.size() != 3) begin
      miscompares++; $display("FAIL single_reads got %0d words required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got_q[i] !== 64'(64'h11 + i)) begin
          miscompares++; $display("FAIL single_rd%0d got %h required %h", i, got_q[i], 64'h11 + i);
        end
      end
    end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL single_done got %0d required 1", done_n); end
  endtask

  task automatic test_multi_bank();
    logic [31:0] e_off[3];
    logic [31:0] e_wd[3];
    e_off = '{32'd0, 32'd8, 32'd0};
    e_wd  = '{32'd8, 32'd8, 32'd4};
    do_reset(1'b0);
    release_reset();
    for (int i = 1; i <= 20; i++) send_beat({$urandom, $urandom}, i == 20);
    wait_done(1);
    vectors++;
    if (kick_off_q.size() != 3) begin
      miscompares++; $display("FAIL multi_kicks got %0d required 3", kick_off_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (kick_off_q[i] !== e_off[i] || kick_words_q[i] !== e_wd[i]) begin
          miscompares++; $display("FAIL multi_kick%0d got (%0d,%0d) required (%0d,%0d)", i, kick_off_q[i], kick_words_q[i], e_off[i], e_wd[i]);
        end
      end
    end
    vectors++; if (got_q != exp_data_q) begin miscompares++; $display("FAIL multi_data got %0d words required %0d matching", got_q.size(), exp_data_q.size()); end
    vectors++; if (done_n != 1 || done_kicks != 3) begin miscompares++; $display("FAIL multi_done got %0d pulses after %0d kicks required 1 after 3", done_n, done_kicks); end
`ifdef RESULT_COLLECTOR_STATS_EN
    vectors++; if (stat_words !== 32'd20) begin miscompares++; $display("FAIL multi_stat_words got %0d required 20", stat_words); end
`else
    vectors++; if (stat_words !== 32'd0) begin miscompares++; $display("FAIL multi_stat_words got %0d required 0", stat_words); end
`endif
  endtask

  task automatic test_back_to_back();
    bit r17;
    r17 = 1'b1;
    do_reset(1'b0);
    release_reset();
    for (int i = 1; i <= 24; i++) begin
      send_beat({$urandom, $urandom}, i == 24);
      if (i == 17) r17 = first_ready;
    end
    wait_done(1);
    vectors++; if (r17 !== 1'b0) begin miscompares++; $display("FAIL bp_ready_after16 got %b required 0", r17); end
    vectors++; if (stall_obs != 14) begin miscompares++; $display("FAIL bp_stall_cycles got %0d required 14", stall_obs); end
    vectors++;
    if (kick_off_q.size() != 3 || kick_words_q[2] !== 32'd8 || kick_off_q[2] !== 32'd0) begin
      miscompares++; $display("FAIL bp_kicks got %0d kicks required 3 ending (0,8)", kick_off_q.size());
    end
    vectors++; if (got_q != exp_data_q) begin miscompares++; $display("FAIL bp_data got %0d words required %0d matching", got_q.size(), exp_data_q.size()); end
`ifdef RESULT_COLLECTOR_STATS_EN
    vectors++; if (stat_stall !== 32'(stall_obs)) begin miscompares++; $display("FAIL bp_stat_stall got %0d required %0d", stat_stall, stall_obs); end
    vectors++; if (stat_words !== 32'd24) begin miscompares++; $display("FAIL bp_stat_words got %0d required 24", stat_words); end
`else
    vectors++; if (stat_stall !== 32'd0) begin miscompares++; $display("FAIL bp_stat_stall got %0d required 0", stat_stall); end
    vectors++; if (stat_words !== 32'd0) begin miscompares++; $display("FAIL bp_stat_words got %0d required 0", stat_words); end
`endif
  endtask

  task automatic test_busy_hold();
    cp_hold = 1'b1;
    do_reset(1'b0);
    release_reset();
    send_beat(64'hA1, 1'b0);
    send_beat(64'hA2, 1'b0);
    send_beat(64'hA3, 1'b1);
    gap(45);
    vectors++; if (kick_off_q.size() != 0) begin miscompares++; $display("FAIL hold_early_kick got %0d kicks required 0", kick_off_q.size()); end
    cp_hold = 1'b0;
    wait_done(1);
    vectors++;
    if (kick_off_q.size() != 1 || kick_off_q[0] !== 32'd0 || kick_words_q[0] !== 32'd3) begin
      miscompares++; $display("FAIL hold_kick got %0d kicks required one (0,3)", kick_off_q.size());
    end
    vectors++; if (got_q != exp_data_q) begin miscompares++; $display("FAIL hold_data got %0d words required %0d matching", got_q.size(), exp_data_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(1'b0);
    release_reset();
    for (int i = 1; i <= 16; i++) send_beat({$urandom, $urandom}, 1'b0);
    gap(3);
    n = 0;
    while (kick_off_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    #1;
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready_sealed got %b required 0", s_ready); end
    do_reset(1'b1);
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready got %b required 1", s_ready); end
    vectors++; if (copy_kick !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_kickdone got %b,%b required 0,0", copy_kick, done); end
    release_reset();
    send_beat(64'hC0FFEE, 1'b0);
    send_beat(64'hBEEF, 1'b1);
    wait_done(1);
    vectors++;
    if (kick_off_q.size() != 1 || kick_off_q[0] !== 32'd0 || kick_words_q[0] !== 32'd2) begin
      miscompares++; $display("FAIL mid_fresh_kick got %0d kicks required one (0,2)", kick_off_q.size());
    end
    vectors++; if (got_q != exp_data_q) begin miscompares++; $display("FAIL mid_data got %0d words required %0d matching", got_q.size(), exp_data_q.size()); end
  endtask

  task automatic test_random();
    int len;
    do_reset(1'b0);
    release_reset();
    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(20, 1);
      for (int i = 1; i <= len; i++) begin
        send_beat({$urandom, $urandom}, i == len);
        gap($urandom_range(2, 0));
      end
    end
    wait_done(exp_done);
    vectors++;
    if (kick_off_q.size() != exp_off_q.size()) begin
      miscompares++; $display("FAIL rand_kicks got %0d required %0d", kick_off_q.size(), exp_off_q.size());
    end else begin
      for (int i = 0; i < exp_off_q.size(); i++) begin
        vectors++;
        if (kick_off_q[i] !== exp_off_q[i] || kick_words_q[i] !== exp_words_q[i]) begin
          miscompares++; $display("FAIL rand_kick%0d got (%0d,%0d) required (%0d,%0d)", i, kick_off_q[i], kick_words_q[i], exp_off_q[i], exp_words_q[i]);
        end
      end
    end
    vectors++; if (got_q != exp_data_q) begin miscompares++; $display("FAIL rand_data got %0d words required %0d matching", got_q.size(), exp_data_q.size()); end
    vectors++; if (done_n != exp_done) begin miscompares++; $display("FAIL rand_done got %0d required %0d", done_n, exp_done); end
`ifdef RESULT_COLLECTOR_STATS_EN
    vectors++; if (stat_words !== 32'(beats_acc)) begin miscompares++; $display("FAIL rand_stat_words got %0d required %0d", stat_words, beats_acc); end
`else
    vectors++; if (stat_words !== 32'd0) begin miscompares++; $display("FAIL rand_stat_words got %0d required 0", stat_words); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_bank();
    test_back_to_back();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
